// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel filter over a raster pixel stream.
// Two line buffers feed a 3x3 window, and one registered result is produced per interior pixel.
module sobel_stream #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic [DATA_WIDTH-1:0] i_pix,
    input  logic [1:0]            i_mode,
    output logic                  o_valid,
    output logic [DATA_WIDTH+3:0] o_val,
    output logic                  o_eol,
    output logic                  o_eof,
    output logic                  o_drop
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int GW = DATA_WIDTH + 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;

    logic                  accept, drop_d, last_pix;
    logic [CW-1:0]         col_q, col_d, pos_c;
    logic [RW-1:0]         row_q, row_d, pos_r;
    logic [1:0]            mode_q, mode_d;
    logic                  pend_q, pend_d, pend_eol_q, pend_eol_d, pend_eof_q, pend_eof_d;
    logic                  valid_q, valid_d, eol_q, eol_d, eof_q, eof_d, drop_q;
    logic [DATA_WIDTH+3:0] val_q, val_d, res;
    logic [DATA_WIDTH-1:0] win_q [3][3];
    logic [DATA_WIDTH-1:0] win_d [3][3];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
    logic [GW-1:0]         lx, rx, ty, by, ax, ay;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // A frame start is always accepted at (0,0); the final pixel closes the frame.
    always_comb begin
        state_d = !accept ? state_q : last_pix ? IDLE : ACTIVE;
    end

    always_comb begin
        accept   = i_valid && (state_q == ACTIVE || i_sof);
        drop_d   = i_valid && state_q == IDLE && !i_sof;
        pos_c    = i_sof ? '0 : col_q;
        pos_r    = i_sof ? '0 : row_q;
        last_pix = pos_c == COL_LAST && pos_r == ROW_LAST;
    end

    always_comb begin
        col_d      = !accept ? col_q : (pos_c == COL_LAST) ? '0 : pos_c + CW'(1);
        row_d      = !accept ? row_q : last_pix ? '0 : (pos_c == COL_LAST) ? pos_r + RW'(1) : pos_r;
        mode_d     = (accept && i_sof) ? i_mode : mode_q;
        pend_d     = accept && pos_r >= RW'(2) && pos_c >= CW'(2);
        pend_eol_d = pos_c == COL_LAST;
        pend_eof_d = last_pix;
        win_d      = win_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb2_q[pos_c];
            win_d[1][2] = lb1_q[pos_c];
            win_d[2][2] = i_pix;
        end
    end

    // Gradients kept as magnitudes of two non-negative weighted sums to stay unsigned.
    always_comb begin
        lx  = GW'(win_q[0][0]) + GW'({win_q[1][0], 1'b0}) + GW'(win_q[2][0]);
        rx  = GW'(win_q[0][2]) + GW'({win_q[1][2], 1'b0}) + GW'(win_q[2][2]);
        ty  = GW'(win_q[0][0]) + GW'({win_q[0][1], 1'b0}) + GW'(win_q[0][2]);
        by  = GW'(win_q[2][0]) + GW'({win_q[2][1], 1'b0}) + GW'(win_q[2][2]);
        ax  = (rx >= lx) ? rx - lx : lx - rx;
        ay  = (by >= ty) ? by - ty : ty - by;
        res = (mode_q == 2'd0) ? {2'b0, ax} :
              (mode_q == 2'd1) ? {2'b0, ay} :
              (mode_q == 2'd2) ? {2'b0, ax} + {2'b0, ay} : {4'b0, win_q[1][1]};
        valid_d = pend_q;
        eol_d   = pend_q && pend_eol_q;
        eof_d   = pend_q && pend_eof_q;
        val_d   = pend_q ? res : val_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            mode_q     <= '0;
            pend_q     <= 1'b0;
            pend_eol_q <= 1'b0;
            pend_eof_q <= 1'b0;
            valid_q    <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            drop_q     <= 1'b0;
            val_q      <= '0;
            win_q      <= '{default: '0};
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            pend_eol_q <= pend_eol_d;
            pend_eof_q <= pend_eof_d;
            valid_q    <= valid_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
            drop_q     <= drop_d;
            val_q      <= val_d;
            win_q      <= win_d;
        end
    end

    // Line storage is deliberately unreset; stale lines are never used before row 2.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1_q[pos_c] <= i_pix;
            lb2_q[pos_c] <= lb1_q[pos_c];
        end
    end

    assign o_valid = valid_q;
    assign o_val   = val_q;
    assign o_eol   = eol_q;
    assign o_eof   = eof_q;
    assign o_drop  = drop_q;
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: directed checks of sobel_stream on a 4x4, 8-bit image.
module tb_sobel_stream;
    logic        clk = 0, rst_n = 0, i_valid = 0, i_sof = 0;
    logic [7:0]  i_pix = 0;
    logic [1:0]  i_mode = 0;
    logic        o_valid, o_eol, o_eof, o_drop;
    logic [11:0] o_val;
    int          checks = 0, failures = 0, cyc = 0, drops = 0, nres = 0, nexp = 0;
    logic [11:0] rv [16];
    logic [1:0]  rm [16];
    int          rc [16];
    int          ec [16];
    logic [7:0]  frm [16];
    logic [1:0]  mk [4] = '{2'b00, 2'b10, 2'b00, 2'b11};

    sobel_stream #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_pix(i_pix),
        .i_mode(i_mode), .o_valid(o_valid), .o_val(o_val), .o_eol(o_eol), .o_eof(o_eof),
        .o_drop(o_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Results are captured on the falling edge, tagged with {eol,eof} and the cycle seen.
    always @(negedge clk) begin
        if (o_valid && nres < 16) begin
            rv[nres] = o_val;
            rm[nres] = {o_eol, o_eof};
            rc[nres] = cyc;
            nres++;
        end
        if (o_drop) drops++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 0;
            i_sof = 0;
        end
    endtask

    task automatic beat(input logic [7:0] p, input logic sof);
        @(negedge clk);
        i_valid = 1;
        i_sof = sof;
        i_pix = p;
    endtask

    // Mode is inverted after the start beat so that only the latched mode can be in effect.
    task automatic drive_frame(input logic [1:0] mode, input int bub);
        nres = 0;
        nexp = 0;
        drops = 0;
        for (int i = 0; i < 16; i++) rv[i] = 'x;
        for (int i = 0; i < 16; i++) begin
            if (bub != 0) idle(int'($urandom_range(bub, 0)));
            @(negedge clk);
            i_valid = 1;
            i_sof = (i == 0);
            i_pix = frm[i];
            i_mode = (i == 0) ? mode : ~mode;
            if (i / 4 >= 2 && i % 4 >= 2) begin
                ec[nexp] = cyc + 2;
                nexp++;
            end
        end
        idle(4);
    endtask

    task automatic test_reset;
        beat(8'd50, 1);
        idle(2);
        checks++;
        if ({o_valid, o_eol, o_eof, o_drop} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {o_valid, o_eol, o_eof, o_drop});
        end
        checks++;
        if (o_val !== 12'd0) begin
            failures++;
            $display("FAIL reset_val got=%0d exp=0", o_val);
        end
        rst_n = 1;
        idle(2);
        checks++;
        if (nres !== 0 || drops !== 0) begin
            failures++;
            $display("FAIL reset_quiet got res=%0d drops=%0d exp 0 0", nres, drops);
        end
    endtask

    task automatic test_flat;
        for (int i = 0; i < 16; i++) frm[i] = 8'd100;
        drive_frame(2'd2, 0);
        checks++;
        if (nres !== 4) begin
            failures++;
            $display("FAIL flat_count got=%0d exp=4", nres);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv[i] !== 12'd0 || rm[i] !== mk[i] || rc[i] !== ec[i]) begin
                failures++;
                $display("FAIL flat_res%0d got val=%0d mk=%b cyc=%0d exp val=0 mk=%b cyc=%0d",
                         i, rv[i], rm[i], rc[i], mk[i], ec[i]);
            end
        end
    endtask

    task automatic test_bubbles;
        for (int i = 0; i < 16; i++) frm[i] = 8'd100;
        drive_frame(2'd2, 3);
        checks++;
        if (nres !== 4) begin
            failures++;
            $display("FAIL bub_count got=%0d exp=4", nres);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv[i] !== 12'd0 || rm[i] !== mk[i] || rc[i] !== ec[i]) begin
                failures++;
                $display("FAIL bub_res%0d got val=%0d mk=%b cyc=%0d exp val=0 mk=%b cyc=%0d",
                         i, rv[i], rm[i], rc[i], mk[i], ec[i]);
            end
        end
    endtask

    task automatic test_cols;
        logic [11:0] e [2] = '{12'd1020, 12'd0};
        for (int i = 0; i < 16; i++) frm[i] = (i % 4 >= 2) ? 8'd255 : 8'd0;
        for (int m = 0; m < 2; m++) begin
            drive_frame(2'(m), 0);
            checks++;
            if (nres !== 4) begin
                failures++;
                $display("FAIL cols_m%0d_count got=%0d exp=4", m, nres);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rv[i] !== e[m] || rm[i] !== mk[i]) begin
                    failures++;
                    $display("FAIL cols_m%0d_res%0d got val=%0d mk=%b exp val=%0d mk=%b",
                             m, i, rv[i], rm[i], e[m], mk[i]);
                end
            end
        end
    endtask

    task automatic test_rows;
        logic [11:0] e [3][4] = '{'{12'd1020, 12'd1020, 12'd1020, 12'd1020},
                                  '{12'd1020, 12'd1020, 12'd1020, 12'd1020},
                                  '{12'd0, 12'd0, 12'd255, 12'd255}};
        for (int i = 0; i < 16; i++) frm[i] = (i / 4 >= 2) ? 8'd255 : 8'd0;
        for (int m = 0; m < 3; m++) begin
            drive_frame(2'(m + 1), 0);
            checks++;
            if (nres !== 4) begin
                failures++;
                $display("FAIL rows_m%0d_count got=%0d exp=4", m + 1, nres);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rv[i] !== e[m][i]) begin
                    failures++;
                    $display("FAIL rows_m%0d_res%0d got=%0d exp=%0d", m + 1, i, rv[i], e[m][i]);
                end
            end
        end
        checks++;
        if (o_valid !== 1'b0 || o_val !== 12'd255) begin
            failures++;
            $display("FAIL hold_val got valid=%b val=%0d exp valid=0 val=255", o_valid, o_val);
        end
    endtask

    task automatic test_ramp;
        logic [11:0] e [2][4] = '{'{12'd104, 12'd104, 12'd104, 12'd104},
                                  '{12'd13, 12'd23, 12'd16, 12'd26}};
        for (int i = 0; i < 16; i++) frm[i] = 8'(10 * (i % 4) + 3 * (i / 4));
        for (int m = 0; m < 2; m++) begin
            drive_frame(2'(m + 2), 0);
            checks++;
            if (nres !== 4) begin
                failures++;
                $display("FAIL ramp_m%0d_count got=%0d exp=4", m + 2, nres);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rv[i] !== e[m][i]) begin
                    failures++;
                    $display("FAIL ramp_m%0d_res%0d got=%0d exp=%0d", m + 2, i, rv[i], e[m][i]);
                end
            end
        end
    endtask

    task automatic test_drop;
        nres = 0;
        drops = 0;
        beat(8'd5, 0);
        beat(8'd6, 0);
        idle(3);
        checks++;
        if (drops !== 2 || nres !== 0) begin
            failures++;
            $display("FAIL drop_pre got drops=%0d res=%0d exp 2 0", drops, nres);
        end
        for (int i = 0; i < 16; i++) frm[i] = 8'd100;
        drive_frame(2'd2, 0);
        beat(8'd7, 0);
        idle(3);
        checks++;
        if (drops !== 1 || nres !== 4) begin
            failures++;
            $display("FAIL drop_post got drops=%0d res=%0d exp 1 4", drops, nres);
        end
    endtask

    task automatic test_restart;
        nres = 0;
        for (int i = 0; i < 6; i++) beat(8'd255, i == 0);
        for (int i = 0; i < 16; i++) frm[i] = 8'd100;
        drive_frame(2'd2, 0);
        checks++;
        if (nres !== 4 || rv[0] !== 12'd0 || rv[3] !== 12'd0 || rm[3] !== 2'b11) begin
            failures++;
            $display("FAIL restart got res=%0d v0=%0d v3=%0d mk3=%b exp 4 0 0 11",
                     nres, rv[0], rv[3], rm[3]);
        end
    endtask

    task automatic test_abort;
        nres = 0;
        for (int i = 0; i < 16; i++) frm[i] = 8'(10 * (i % 4) + 3 * (i / 4));
        for (int i = 0; i < 9; i++) beat(frm[i], i == 0);
        @(negedge clk);
        rst_n = 0;
        i_valid = 0;
        i_sof = 0;
        idle(2);
        checks++;
        if (nres !== 0 || o_valid !== 1'b0 || o_val !== 12'd0) begin
            failures++;
            $display("FAIL abort_quiet got res=%0d valid=%b val=%0d exp 0 0 0", nres, o_valid, o_val);
        end
        rst_n = 1;
        drive_frame(2'd2, 0);
        checks++;
        if (nres !== 4) begin
            failures++;
            $display("FAIL abort_count got=%0d exp=4", nres);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv[i] !== 12'd104 || rm[i] !== mk[i]) begin
                failures++;
                $display("FAIL abort_res%0d got val=%0d mk=%b exp val=104 mk=%b", i, rv[i], rm[i], mk[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_bubbles();
        test_cols();
        test_rows();
        test_ramp();
        test_drop();
        test_restart();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
